// File: rtl/bitbrick_seq_mul.sv
// Variable-precision (2/4/8-bit) signed/unsigned multiplier that time-multiplexes a
// single 2x2 bitbrick over every digit pair, one pair per cycle, into an accumulator.

module bitbrick (
    input  logic [1:0] x_i,
    input  logic [1:0] y_i,
    input  logic       sx_i,
    input  logic       sy_i,
    input  logic       shift_i,
    output logic [5:0] prod_o
);
    logic signed [5:0] xw;
    logic signed [5:0] yw;
    logic signed [5:0] p;

    // A signed digit is sign-extended from its bit 1; an unsigned one is zero-extended.
    assign xw = {{4{sx_i & x_i[1]}}, x_i};
    assign yw = {{4{sy_i & y_i[1]}}, y_i};
    assign p  = xw * yw;

    assign prod_o = shift_i ? {p[3:0], 2'b00} : p;
endmodule

module bitbrick_seq_mul #(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] in_x,
    input  logic                in_sx,
    input  logic [MAX_BITS-1:0] in_y,
    input  logic                in_sy,
    input  logic [1:0]          in_prec_x,
    input  logic [1:0]          in_prec_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_result,
    output logic                busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [MAX_BITS-1:0] x_q, x_d;
    logic [MAX_BITS-1:0] y_q, y_d;
    logic                sx_q, sx_d;
    logic                sy_q, sy_d;
    logic [1:0]          xlast_q, xlast_d;
    logic [1:0]          ylast_q, ylast_d;
    logic [1:0]          i_q, i_d;
    logic [1:0]          j_q, j_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    res_q, res_d;

    logic [1:0]       dig_x;
    logic [1:0]       dig_y;
    logic             bb_sx;
    logic             bb_sy;
    logic [5:0]       prod;
    logic [2:0]       ij_sum;
    logic [3:0]       shamt;
    logic [ACC_W-1:0] term_ext;
    logic [ACC_W-1:0] term_sh;
    logic [ACC_W-1:0] acc_sum;

    // Bits above the selected precision are cleared so the top digit carries the sign.
    function automatic logic [MAX_BITS-1:0] prec_mask(input logic [MAX_BITS-1:0] v,
                                                      input logic [1:0] p);
        case (p)
            2'b00:   return {{(MAX_BITS-2){1'b0}}, v[1:0]};
            2'b01:   return {{(MAX_BITS-4){1'b0}}, v[3:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [1:0] last_digit(input logic [1:0] p);
        case (p)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign dig_x = x_q[{i_q, 1'b0} +: 2];
    assign dig_y = y_q[{j_q, 1'b0} +: 2];
    assign bb_sx = sx_q & (i_q == xlast_q);
    assign bb_sy = sy_q & (j_q == ylast_q);

    bitbrick u_bb (
        .x_i     (dig_x),
        .y_i     (dig_y),
        .sx_i    (bb_sx),
        .sy_i    (bb_sy),
        .shift_i (1'b0),
        .prod_o  (prod)
    );

    assign ij_sum   = {1'b0, i_q} + {1'b0, j_q};
    assign shamt    = {ij_sum, 1'b0};
    assign term_ext = {{(ACC_W-6){prod[5]}}, prod};
    assign term_sh  = term_ext << shamt;
    assign acc_sum  = acc_q + term_sh;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        xlast_d = xlast_q;
        ylast_d = ylast_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = prec_mask(in_x, in_prec_x);
                    y_d     = prec_mask(in_y, in_prec_y);
                    sx_d    = in_sx;
                    sy_d    = in_sy;
                    xlast_d = last_digit(in_prec_x);
                    ylast_d = last_digit(in_prec_y);
                    i_d     = 2'd0;
                    j_d     = 2'd0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                if (j_q == ylast_q) begin
                    j_d = 2'd0;
                    if (i_q == xlast_q) begin
                        i_d     = 2'd0;
                        res_d   = acc_sum;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 2'd1;
                    end
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            xlast_q <= 2'd0;
            ylast_q <= 2'd0;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            xlast_q <= xlast_d;
            ylast_q <= ylast_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_result = res_q;
endmodule

// File: doc/bitbrick_seq_mul.md
Name: bitbrick_seq_mul

Overview:
- Temporal controller that reuses one internal `bitbrick` instance (2-bit × 2-bit signed/unsigned multiplier, 6-bit product) to compute a variable-precision product.
- Operand precisions are 2, 4 or 8 bits.
- It decomposes both operands into 2-bit digits and walks every digit pair, one pair per cycle. Each partial product is sign-extended, shifted and summed into an accumulator.
- Sits between the operand-fetch stage and the output buffer. Valid/ready handshakes on both sides.

Parameters:
- MAX_BITS, 8, maximum operand width; must be 8.
- ACC_W, 18, accumulator/result width; must be ≥ 17 to hold the 8×8 mixed-sign range.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand request.
- in_x  in  MAX_BITS  operand X; bits above the selected precision are ignored.
- in_sx  in  1  1 = X is two's complement, 0 = unsigned.
- in_y  in  MAX_BITS  operand Y; bits above the selected precision are ignored.
- in_sy  in  1  1 = Y is two's complement, 0 = unsigned.
- in_prec_x  in  2  X precision: 00 = 2b, 01 = 4b, 10 = 8b, 11 = 8b (reserved, treated as 8b).
- in_prec_y  in  2  Y precision, same encoding as in_prec_x.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  ACC_W  signed product, sign-extended to ACC_W.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: asserting rst immediately forces state IDLE, accumulator = 0, digit counters = 0, out_valid = 0, out_result = 0, busy = 0. in_ready = 1 once in IDLE. Reset mid-RUN or mid-DONE abandons the operation; no result is produced.
- FSM: IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register x, y, sx, sy and the digit counts Nx, Ny (1, 2 or 4 = bits/2).
  - Clear the accumulator and set counters i = 0, j = 0. Go to RUN.
- RUN, each cycle:
  - Drive the bitbrick with x = X digit i, y = Y digit j.
  - s_x = sx & (i == Nx−1); s_y = sy & (j == Ny−1). Only the top digit of a signed operand is signed; lower digits are unsigned.
  - The bitbrick's shift input is tied to 0. prod[5:0] is taken as a signed 6-bit value and sign-extended to ACC_W.
  - The extended value is shifted left by 2·(i+j) and added to the accumulator.
  - j increments each cycle. When j reaches Ny−1, j wraps to 0 and i increments.
  - The final pair is i = Nx−1, j = Ny−1. After accumulating it, load out_result and go to DONE.
- RUN length: exactly Nx·Ny cycles (1 to 16).
  - out_valid rises Nx·Ny rising edges after the accepting edge. For a 2b×2b request, that is the next edge.
- DONE:
  - out_valid = 1, out_result held stable.
  - On out_ready, go to IDLE with out_valid = 0.
  - in_ready = 0 during RUN and DONE; in_valid is ignored there (no queueing).
  - A new request can therefore be accepted at the earliest one cycle after out_valid & out_ready.
- Arithmetic:
  - All accumulation is two's complement in ACC_W bits; the ACC_W ≥ 17 constraint guarantees no overflow.
  - Unsigned operands have effective value 0 to 2^bits−1.
  - Precision masking applies before digit extraction. The sign bit of an operand is bit (bits−1) of the selected precision, not bit MAX_BITS−1.
- out_result holds its last value in IDLE.

Test Plan:
- prec 2b/2b unsigned, x = 3, y = 3 → out_valid one edge after acceptance, out_result = 9; then x = 2, y = 2 with sx = sy = 1 (−2 × −2) → 4.
- prec 8b/8b signed, x = 0x80, y = 0x80 → exactly 16 RUN cycles, out_result = 16384; then x = 0x7F, y = 0x80 → −16256.
- prec 8b/8b unsigned, x = 0xFF, y = 0xFF → out_result = 65025.
- prec 4b/8b, in_x = 0xF7 with sx = 1 (upper nibble ignored, X = 7), y = 0xFF with sy = 0 (Y = 255) → 8 RUN cycles, out_result = 1785. Repeat with in_x = 0x08, sx = 1 (X = −8) → −2040.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid while pulsing in_valid → out_valid and out_result stable, in_ready = 0, no request accepted. Then raise out_ready → IDLE, and a new request is accepted on the following cycle.
- Assert rst during RUN cycle 5 of an 8b/8b request → out_valid = 0, in_ready = 1 after reset releases, no result emitted. A subsequent 2b/2b request of 1 × 1 returns 1.
